// File: rtl/trunc_add_vec_pipe_if.sv
// Handshake and data bundle for the SIMD truncating adder.
// The master side feeds operands and consumes results; the slave side is the adder.
interface trunc_add_vec_pipe_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] in_a;
    logic [LANES*WIDTH-1:0] in_b;
    logic [LANES-1:0]       in_cin;
    logic                   in_round;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] out_sum;
    logic [LANES-1:0]       out_sat;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_round, out_ready,
        input  in_ready, out_valid, out_sum, out_sat
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_round, out_ready,
        output in_ready, out_valid, out_sum, out_sat
    );
endinterface

// File: rtl/trunc_add_vec_pipe.sv
// LANES-wide SIMD adder: per lane (a + b + cin) >>> SHIFT with optional round-half-up
// and saturation; two register stages with valid/ready backpressure.
module trunc_add_vec_pipe #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int SHIFT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    trunc_add_vec_pipe_if.slave  bus
);
    // Two guard bits cover a + b + cin over the full signed operand range.
    localparam int FW = WIDTH + 2;
    localparam logic signed [FW-1:0] QMAX = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [FW-1:0] QMIN = {3'b111, {(WIDTH-1){1'b0}}};

    function automatic logic signed [FW-1:0] sxt(input logic [WIDTH-1:0] x);
        return {{2{x[WIDTH-1]}}, x};
    endfunction

    function automatic logic signed [FW-1:0] round_shift(input logic signed [FW-1:0] full,
                                                         input logic rnd);
        logic signed [FW-1:0] bias;
        bias = '0;
        if (rnd) bias[SHIFT-1] = 1'b1;
        return (full + bias) >>> SHIFT;
    endfunction

    // Returns {sat, value}.
    function automatic logic [WIDTH:0] saturate(input logic signed [FW-1:0] q);
        if (q > QMAX) return {1'b1, QMAX[WIDTH-1:0]};
        if (q < QMIN) return {1'b1, QMIN[WIDTH-1:0]};
        return {1'b0, q[WIDTH-1:0]};
    endfunction

    logic                   vld_p1;
    logic                   vld_p2;
    logic                   rnd_p1;
    logic signed [FW-1:0]   full_p1 [LANES];
    logic signed [FW-1:0]   full_d  [LANES];
    logic [LANES*WIDTH-1:0] sum_d;
    logic [LANES*WIDTH-1:0] sum_p2;
    logic [LANES-1:0]       sat_d;
    logic [LANES-1:0]       sat_p2;
    logic                   s2_adv;
    logic                   s1_load;

    assign s2_adv       = !vld_p2 || bus.out_ready;
    assign bus.in_ready = !vld_p1 || s2_adv;
    assign s1_load      = bus.in_valid && bus.in_ready;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            full_d[i] = sxt(bus.in_a[i*WIDTH +: WIDTH]) + sxt(bus.in_b[i*WIDTH +: WIDTH])
                      + FW'(bus.in_cin[i]);
        end
    end

    always_comb begin
        sum_d = '0;
        sat_d = '0;
        for (int i = 0; i < LANES; i++) begin
            {sat_d[i], sum_d[i*WIDTH +: WIDTH]} = saturate(round_shift(full_p1[i], rnd_p1));
        end
    end

    // Stage boundary p1: widened lane sums plus the beat's rounding mode.
    always_ff @(posedge clk) begin
        if (s1_load) begin
            full_p1 <= full_d;
            rnd_p1  <= bus.in_round;
        end
    end

    // Stage boundary p2: rounded, shifted, clamped results; outputs hold when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            sum_p2 <= '0;
            sat_p2 <= '0;
        end else begin
            if (bus.in_ready) vld_p1 <= bus.in_valid;
            if (s2_adv) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    sum_p2 <= sum_d;
                    sat_p2 <= sat_d;
                end
            end
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.out_sum   = sum_p2;
    assign bus.out_sat   = sat_p2;
endmodule

// File: tb/tb_trunc_add_vec_pipe.sv
// Bench for trunc_add_vec_pipe: directed literal beats on two parameterisations plus
// randomized traffic scored against a lane-wise arithmetic model.
module tb_trunc_add_vec_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trunc_add_vec_pipe_if #(.WIDTH(8), .LANES(4)) ba ();
    trunc_add_vec_pipe #(.WIDTH(8), .LANES(4), .SHIFT(1)) dut_a (
        .clk(clk), .rst(rst), .bus(ba.slave));

    trunc_add_vec_pipe_if #(.WIDTH(12), .LANES(2)) bb ();
    trunc_add_vec_pipe #(.WIDTH(12), .LANES(2), .SHIFT(3)) dut_b (
        .clk(clk), .rst(rst), .bus(bb.slave));

    typedef struct packed {
        logic [31:0] s;
        logic [3:0]  sat;
    } beat_t;

    int    checks   = 0;
    int    failures = 0;
    int    n_out    = 0;
    beat_t q_exp[$];
    bit    held_v   = 0;
    logic [31:0] held_s;
    logic [3:0]  held_sat;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Lane arithmetic straight from the definition: exact sum, optional half-LSB bias,
    // floor division by 2^s, then clamp into the signed w-bit range.
    function automatic longint model(input longint a, input longint b, input longint cin,
                                     input bit rnd, input int w, input int s, output bit sat);
        longint r, q, mx, mn;
        r  = a + b + cin + (rnd ? (longint'(1) << (s - 1)) : 64'sd0);
        q  = r >>> s;
        mx = (longint'(1) << (w - 1)) - 1;
        mn = -(longint'(1) << (w - 1));
        sat = 1'b0;
        if (q > mx) begin sat = 1'b1; q = mx; end
        else if (q < mn) begin sat = 1'b1; q = mn; end
        return q;
    endfunction

    function automatic beat_t expect_a(input logic [31:0] a, input logic [31:0] b,
                                       input logic [3:0] cin, input logic rnd);
        beat_t  e;
        longint av, bv, q;
        bit     s;
        e = '0;
        for (int i = 0; i < 4; i++) begin
            av = longint'($signed(a[i*8 +: 8]));
            bv = longint'($signed(b[i*8 +: 8]));
            q  = model(av, bv, longint'(cin[i]), rnd, 8, 1, s);
            e.s[i*8 +: 8] = q[7:0];
            e.sat[i]      = s;
        end
        return e;
    endfunction

    function automatic logic [31:0] rep8(input int x);
        logic [7:0] t;
        t = x[7:0];
        return {4{t}};
    endfunction

    function automatic logic [31:0] rep12(input int x);
        logic [11:0] t;
        t = x[11:0];
        return {8'h00, t, t};
    endfunction

    // Scoreboard on dut_a: sampled on the falling edge, between driver updates.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            q_exp.delete();
            held_v = 0;
        end else begin
            if (held_v) begin
                chk("hold_valid", longint'(ba.out_valid), 1);
                chk("hold_sum", longint'(ba.out_sum), longint'(held_s));
                chk("hold_sat", longint'(ba.out_sat), longint'(held_sat));
            end
            if (ba.out_valid && ba.out_ready) begin
                if (q_exp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got sum %0h, expected no beat", ba.out_sum);
                end else begin
                    e = q_exp.pop_front();
                    chk("sb_sum", longint'(ba.out_sum), longint'(e.s));
                    chk("sb_sat", longint'(ba.out_sat), longint'(e.sat));
                    n_out++;
                end
            end
            held_v   = ba.out_valid && !ba.out_ready;
            held_s   = ba.out_sum;
            held_sat = ba.out_sat;
            if (ba.in_valid && ba.in_ready)
                q_exp.push_back(expect_a(ba.in_a, ba.in_b, ba.in_cin, ba.in_round));
        end
    end

    task automatic directed(input bit use_b, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] cin, input logic rnd, input logic [31:0] es,
                            input logic [3:0] esat, input string nm);
        int   n;
        logic v;
        logic rdy;
        @(posedge clk); #1;
        if (!use_b) begin
            ba.in_valid = 1; ba.in_a = a; ba.in_b = b; ba.in_cin = cin;
            ba.in_round = rnd; ba.out_ready = 1;
        end else begin
            bb.in_valid = 1; bb.in_a = a[23:0]; bb.in_b = b[23:0]; bb.in_cin = cin[1:0];
            bb.in_round = rnd; bb.out_ready = 1;
        end
        @(negedge clk);
        rdy = use_b ? bb.in_ready : ba.in_ready;
        chk({nm, "_in_ready"}, longint'(rdy), 1);
        n = 0;
        v = 0;
        while (!v && n < 10) begin
            @(posedge clk); #1;
            ba.in_valid = 0;
            bb.in_valid = 0;
            n++;
            @(negedge clk);
            v = use_b ? bb.out_valid : ba.out_valid;
        end
        chk({nm, "_latency"}, longint'(n), 2);
        if (use_b) begin
            chk({nm, "_sum"}, longint'({8'h00, bb.out_sum}), longint'(es));
            chk({nm, "_sat"}, longint'({2'b00, bb.out_sat}), longint'(esat));
        end else begin
            chk({nm, "_sum"}, longint'(ba.out_sum), longint'(es));
            chk({nm, "_sat"}, longint'(ba.out_sat), longint'(esat));
        end
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int  sent;
        int  cyc;
        int  base;
        bit  saw_low;
        bit  sd;

        rst = 1;
        ba.in_valid = 0; ba.in_a = '0; ba.in_b = '0; ba.in_cin = '0; ba.in_round = 0;
        ba.out_ready = 1;
        bb.in_valid = 0; bb.in_a = '0; bb.in_b = '0; bb.in_cin = '0; bb.in_round = 0;
        bb.out_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", longint'(ba.out_valid), 0);
        chk("rst_out_sum", longint'(ba.out_sum), 0);
        chk("rst_out_sat", longint'(ba.out_sat), 0);
        chk("rst_in_ready", longint'(ba.in_ready), 1);
        chk("rst_b_out_valid", longint'(bb.out_valid), 0);
        @(posedge clk); #1;
        rst = 0;

        // Model pinned to hand-computed values.
        chk("model_trunc", model(5, 2, 0, 0, 8, 1, sd), 3);
        chk("model_floor_neg", model(-5, 2, 0, 0, 8, 1, sd), -2);
        chk("model_round_neg", model(-5, 2, 0, 1, 8, 1, sd), -1);
        chk("model_sat_val", model(127, 127, 1, 1, 8, 1, sd), 127);
        chk("model_sat_flag", longint'(sd), 1);

        directed(0, rep8(5),    rep8(2),    4'h0, 0, rep8(3),    4'h0, "t1");
        directed(0, rep8(5),    rep8(2),    4'h0, 1, rep8(4),    4'h0, "t2a");
        directed(0, rep8(-5),   rep8(2),    4'h0, 0, rep8(-2),   4'h0, "t2b");
        directed(0, rep8(-5),   rep8(2),    4'h0, 1, rep8(-1),   4'h0, "t2c");
        directed(0, rep8(127),  rep8(127),  4'hf, 1, rep8(127),  4'hf, "t3a");
        directed(0, rep8(127),  rep8(127),  4'hf, 0, rep8(127),  4'h0, "t3b");
        directed(0, rep8(-128), rep8(-128), 4'h0, 0, rep8(-128), 4'h0, "t3c");
        directed(0, 32'h0000007f, 32'h00000001, 4'h1, 0, 32'h00000040, 4'h0, "t5");

        directed(1, rep12(40),    rep12(2),     4'h0, 0, rep12(5),    4'h0, "w12_t1");
        directed(1, rep12(44),    rep12(0),     4'h0, 1, rep12(6),    4'h0, "w12_t2a");
        directed(1, rep12(-45),   rep12(2),     4'h0, 0, rep12(-6),   4'h0, "w12_t2b");
        directed(1, rep12(-45),   rep12(2),     4'h0, 1, rep12(-5),   4'h0, "w12_t2c");
        directed(1, rep12(2047),  rep12(2047),  4'h3, 1, rep12(512),  4'h0, "w12_t3a");
        directed(1, rep12(-2048), rep12(-2048), 4'h0, 0, rep12(-512), 4'h0, "w12_t3c");

        // Backpressure: 10 beats, out_ready low for three cycles mid-stream.
        base = n_out;
        sent = 0;
        cyc = 0;
        saw_low = 0;
        while (sent < 10 && cyc < 100) begin
            @(posedge clk); #1;
            ba.out_ready = !(cyc >= 3 && cyc < 6);
            ba.in_valid  = 1;
            ba.in_a = $urandom; ba.in_b = $urandom;
            ba.in_cin = 4'($urandom_range(0, 15)); ba.in_round = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!ba.in_ready) saw_low = 1;
            else sent++;
            cyc++;
        end
        @(posedge clk); #1;
        ba.in_valid = 0;
        ba.out_ready = 1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("t4_in_ready_dropped", longint'(saw_low), 1);
        chk("t4_beats_out", longint'(n_out - base), 10);

        // Reset with two beats in flight.
        @(posedge clk); #1;
        ba.out_ready = 0;
        ba.in_valid = 1; ba.in_a = rep8(5); ba.in_b = rep8(2); ba.in_cin = 0; ba.in_round = 0;
        @(posedge clk); #1;
        ba.in_a = rep8(20);
        @(posedge clk); #1;
        ba.in_valid = 0;
        rst = 1;
        @(negedge clk);
        chk("t6_pre_valid", longint'(ba.out_valid), 1);
        @(posedge clk); #1;
        rst = 0;
        ba.out_ready = 1;
        @(negedge clk);
        chk("t6_out_valid", longint'(ba.out_valid), 0);
        chk("t6_out_sum", longint'(ba.out_sum), 0);
        chk("t6_out_sat", longint'(ba.out_sat), 0);
        chk("t6_in_ready", longint'(ba.in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        chk("t6_dropped", longint'(ba.out_valid), 0);
        directed(0, rep8(-7), rep8(1), 4'h0, 0, rep8(-3), 4'h0, "t6_after");

        // Randomized traffic with random backpressure and occasional extreme operands.
        for (int c = 0; c < 500; c++) begin
            @(posedge clk); #1;
            ba.in_valid  = ($urandom_range(0, 3) != 0);
            ba.out_ready = ($urandom_range(0, 3) != 0);
            ba.in_a = $urandom;
            ba.in_b = $urandom;
            if ($urandom_range(0, 7) == 0) ba.in_a = rep8(127);
            if ($urandom_range(0, 7) == 0) ba.in_b = rep8(-128);
            if ($urandom_range(0, 7) == 0) ba.in_b = rep8(127);
            ba.in_cin   = 4'($urandom_range(0, 15));
            ba.in_round = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        ba.in_valid = 0;
        ba.out_ready = 1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", longint'(q_exp.size()), 0);
        chk("drain_idle_ready", longint'(ba.in_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
